// File: rtl/s_msg_buffer_if.sv
// s_msg_buffer_if: groups the SPI-side, TX-memory and display-side signals of s_msg_buffer.
//   master : the environment (SPI shifter, TX writer, screen logic) driving the buffer
//   slave  : the s_msg_buffer itself
interface s_msg_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    // SPI shifter side
    logic              is_receiveing;
    logic [DATA_W-1:0] i_data;
    logic              is_transmitting;
    logic              SS;
    logic [DATA_W-1:0] o_data;

    // TX message programming
    logic [ADDR_W:0]   tx_len;
    logic              tx_wr_en;
    logic [ADDR_W-1:0] tx_wr_addr;
    logic [DATA_W-1:0] tx_wr_data;

    // Display side
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   frame_len;
    logic              frame_done;
    logic              overflow;

    modport master (
        output is_receiveing, i_data, is_transmitting, SS,
        output tx_len, tx_wr_en, tx_wr_addr, tx_wr_data,
        output rd_addr,
        input  o_data, rd_data, frame_len, frame_done, overflow
    );

    modport slave (
        input  is_receiveing, i_data, is_transmitting, SS,
        input  tx_len, tx_wr_en, tx_wr_addr, tx_wr_data,
        input  rd_addr,
        output o_data, rd_data, frame_len, frame_done, overflow
    );
endinterface

// File: rtl/s_msg_buffer.sv
// s_msg_buffer: SPI-slave message buffer.
//   Collects received bytes into a double-buffered frame memory (frame ends on SS rise),
//   serves a filtered, registered character read port, and feeds a wrapping, programmable
//   transmit message back to the SPI shifter.
// Ports:
//   clk        : system clock, rising edge
//   btn_reset  : asynchronous active-low reset
//   soft_clear : synchronous one-cycle clear of frame/TX state (memories kept)
//   bus        : s_msg_buffer_if.slave (SPI status/data, TX memory port, display port)
module s_msg_buffer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned CHAR_MIN = 32,
    parameter int unsigned CHAR_MAX = 126,
    parameter int unsigned FILL     = 32
) (
    input  logic          clk,
    input  logic          btn_reset,
    input  logic          soft_clear,
    s_msg_buffer_if.slave bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    // ------------------------------------------------------------------
    // SPI-domain status synchronisers: [0],[1] sync stages, [2] history
    // ------------------------------------------------------------------
    logic [2:0] rx_sync;
    logic [2:0] tx_sync;
    logic [2:0] ss_sync;
    logic       rx_evt;
    logic       tx_evt;
    logic       end_evt;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            rx_sync <= 3'b000;
            tx_sync <= 3'b000;
            ss_sync <= 3'b111;
        end else begin
            rx_sync <= {rx_sync[1:0], bus.is_receiveing};
            tx_sync <= {tx_sync[1:0], bus.is_transmitting};
            ss_sync <= {ss_sync[1:0], bus.SS};
        end
    end

    assign rx_evt  = rx_sync[2] & ~rx_sync[1];
    assign tx_evt  = tx_sync[2] & ~tx_sync[1];
    assign end_evt = ~ss_sync[2] & ss_sync[1];

    // ------------------------------------------------------------------
    // RX framing and bank control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_after;
    logic             bank_sel;
    logic             wr_bank;
    logic             rx_store;
    logic             rx_drop;
    logic [PTR_W-1:0] frame_len_q;
    logic             frame_done_q;
    logic             overflow_q;

    // ptr_after already counts a byte arriving in the same cycle as the frame end
    always_comb begin
        rx_store  = rx_evt && (wr_ptr < DEPTH_P);
        rx_drop   = rx_evt && !rx_store;
        ptr_after = wr_ptr + PTR_W'(rx_store);
        wr_bank   = ~bank_sel;
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            wr_ptr       <= '0;
            bank_sel     <= 1'b0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (soft_clear) begin
                wr_ptr      <= '0;
                bank_sel    <= 1'b0;
                frame_len_q <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (rx_drop) begin
                    overflow_q <= 1'b1;
                end
                if (end_evt && (ptr_after != '0)) begin
                    bank_sel     <= ~bank_sel;
                    frame_len_q  <= ptr_after;
                    frame_done_q <= 1'b1;
                    wr_ptr       <= '0;
                end else begin
                    wr_ptr <= ptr_after;
                end
            end
        end
    end

    // Two RX banks; contents are never cleared, frame_len gates what is visible
    logic [DATA_W-1:0] rx_mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (rx_store && !soft_clear) begin
            rx_mem[wr_bank][wr_ptr[ADDR_W-1:0]] <= bus.i_data;
        end
    end

    // ------------------------------------------------------------------
    // Filtered display read port (1-cycle latency)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] disp_byte;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_fill;

    always_comb begin
        disp_byte = rx_mem[bank_sel][bus.rd_addr];
        rd_fill   = (PTR_W'(bus.rd_addr) >= frame_len_q)
                 || (disp_byte < DATA_W'(CHAR_MIN))
                 || (disp_byte > DATA_W'(CHAR_MAX));
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_fill ? DATA_W'(FILL) : disp_byte;
        end
    end

    // ------------------------------------------------------------------
    // TX message memory, reloaded with the default banner on reset
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [DEPTH];

    function automatic logic [DATA_W-1:0] tx_default(input int unsigned idx);
        case (idx)
            0:       return DATA_W'(8'h46); // F
            1:       return DATA_W'(8'h52); // R
            2:       return DATA_W'(8'h4F); // O
            3:       return DATA_W'(8'h4D); // M
            4:       return DATA_W'(8'h20); // space
            5:       return DATA_W'(8'h53); // S
            6:       return DATA_W'(8'h4C); // L
            7:       return DATA_W'(8'h41); // A
            8:       return DATA_W'(8'h56); // V
            9:       return DATA_W'(8'h45); // E
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tx_mem[ADDR_W'(i)] <= tx_default(i);
            end
        end else if (bus.tx_wr_en) begin
            tx_mem[bus.tx_wr_addr] <= bus.tx_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // TX index / output byte
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] tx_idx;
    logic              tx_load;
    logic [PTR_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] idx_nxt;
    logic [DATA_W-1:0] o_data_q;

    // '>=' also recovers cleanly if tx_len shrinks below the current index
    always_comb begin
        idx_inc = PTR_W'(tx_idx) + PTR_W'(1);
        idx_nxt = (idx_inc >= bus.tx_len) ? '0 : idx_inc[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            o_data_q <= '0;
            tx_idx   <= '0;
            tx_load  <= 1'b1;
        end else if (soft_clear) begin
            tx_idx   <= '0;
            tx_load  <= 1'b1;
        end else if (bus.tx_len == '0) begin
            o_data_q <= '0;
            tx_idx   <= '0;
            tx_load  <= 1'b0;
        end else if (tx_load || end_evt) begin
            o_data_q <= tx_mem[0];
            tx_idx   <= '0;
            tx_load  <= 1'b0;
        end else if (tx_evt) begin
            o_data_q <= tx_mem[idx_nxt];
            tx_idx   <= idx_nxt;
        end
    end

    assign bus.o_data     = o_data_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_s_msg_buffer.sv
// tb_s_msg_buffer: self-checking bench for s_msg_buffer (directed tables, corner sequences,
// randomized frames against a queue-based reference model).
module tb_s_msg_buffer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic clk = 1'b0;
    logic btn_reset;
    logic soft_clear;

    always #5 clk = ~clk;

    s_msg_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    s_msg_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .CHAR_MIN(32), .CHAR_MAX(126), .FILL(32)
    ) dut (
        .clk(clk),
        .btn_reset(btn_reset),
        .soft_clear(soft_clear),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // counts every cycle frame_done is high: a longer pulse shows up as extra counts
    always @(posedge clk) begin
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_cur [$];
    logic [7:0] m_disp [$];
    bit         m_ovf;
    int         m_tx_len;
    int         m_tx_k;
    logic [7:0] m_o;
    int         exp_done;

    function automatic logic [7:0] m_first();
        return (m_tx_len == 0) ? 8'h00 : m_mem[0];
    endfunction

    function automatic void m_power_on();
        string s = "FROM SLAVE";
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < 10) ? s[i] : 8'h00;
        m_cur.delete();
        m_disp.delete();
        m_ovf  = 0;
        m_tx_k = 0;
        m_o    = m_first();
    endfunction

    function automatic void m_rx(input logic [7:0] b);
        if (m_cur.size() < DEPTH) m_cur.push_back(b);
        else m_ovf = 1;
    endfunction

    function automatic void m_end();
        if (m_cur.size() > 0) begin
            m_disp = m_cur;
            exp_done++;
        end
        m_cur.delete();
        m_tx_k = 0;
        m_o    = m_first();
    endfunction

    function automatic void m_tx();
        if (m_tx_len == 0) m_o = 8'h00;
        else begin
            m_tx_k++;
            m_o = m_mem[m_tx_k % m_tx_len];
        end
    endfunction

    function automatic logic [7:0] m_read(input int a);
        logic [7:0] b;
        if (a >= m_disp.size()) return 8'h20;
        b = m_disp[a];
        return (b < 8'd32 || b > 8'd126) ? 8'h20 : b;
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_data = b;
        bus.is_receiveing = 1'b1;
        cyc(2);
        bus.is_receiveing = 1'b0;
        cyc(5);
        m_rx(b);
    endtask

    task automatic tx_pulse();
        bus.is_transmitting = 1'b1;
        cyc(2);
        bus.is_transmitting = 1'b0;
        cyc(5);
        m_tx();
    endtask

    task automatic frame_start();
        bus.SS = 1'b0;
        cyc(4);
    endtask

    task automatic frame_end();
        bus.SS = 1'b1;
        cyc(5);
        m_end();
    endtask

    task automatic pulse_clear();
        soft_clear = 1'b1;
        cyc(1);
        soft_clear = 1'b0;
        cyc(1);
        m_cur.delete();
        m_disp.delete();
        m_ovf  = 0;
        m_tx_k = 0;
        m_o    = m_first();
    endtask

    task automatic read_chk(input string name, input int a, input logic [7:0] exp);
        bus.rd_addr = ADDR_W'(a);
        cyc(1);
        chk(name, bus.rd_data, exp);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dexp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        string tx_exp;
        vecs[0]  = '{8'h48, 8'h48};
        vecs[1]  = '{8'h49, 8'h49};
        vecs[2]  = '{8'h07, 8'h20};
        vecs[3]  = '{8'h7F, 8'h20};
        vecs[4]  = '{8'h1F, 8'h20};
        vecs[5]  = '{8'h20, 8'h20};
        vecs[6]  = '{8'h7E, 8'h7E};
        vecs[7]  = '{8'h41, 8'h41};
        vecs[8]  = '{8'h80, 8'h20};
        vecs[9]  = '{8'hFF, 8'h20};
        vecs[10] = '{8'h00, 8'h20};

        btn_reset = 1'b0;
        soft_clear = 1'b0;
        bus.is_receiveing = 1'b0;
        bus.is_transmitting = 1'b0;
        bus.i_data = 8'h00;
        bus.SS = 1'b1;
        bus.tx_len = 7'd10;
        bus.tx_wr_en = 1'b0;
        bus.tx_wr_addr = '0;
        bus.tx_wr_data = '0;
        bus.rd_addr = '0;
        m_tx_len = 10;
        exp_done = 0;
        m_power_on();

        // reset values
        cyc(3);
        chk("rst_o_data", bus.o_data, 8'h00);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_frame_len", bus.frame_len, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        btn_reset = 1'b1;
        cyc(1);
        chk("rst_first_load", bus.o_data, 8'h46);

        // "HI" with exact frame_done timing
        frame_start();
        send_byte(8'h48);
        send_byte(8'h49);
        bus.SS = 1'b1;
        cyc(2);
        chk("hi_done_early", bus.frame_done, 0);
        cyc(1);
        chk("hi_done_pulse", bus.frame_done, 1);
        chk("hi_frame_len", bus.frame_len, 2);
        cyc(1);
        chk("hi_done_low", bus.frame_done, 0);
        m_end();
        read_chk("hi_rd0", 0, 8'h48);
        read_chk("hi_rd1", 1, 8'h49);
        read_chk("hi_rd2", 2, 8'h20);
        chk("hi_done_cnt", done_cnt, 1);

        // table-driven filtering
        frame_start();
        for (int i = 0; i < 11; i++) send_byte(vecs[i].din);
        frame_end();
        chk("tbl_frame_len", bus.frame_len, 11);
        for (int i = 0; i < 11; i++) read_chk("tbl_rd", i, vecs[i].dexp);
        read_chk("tbl_rd_past", 11, 8'h20);
        read_chk("tbl_rd_last", 63, 8'h20);

        // 0x07, 0x7F
        frame_start();
        send_byte(8'h07);
        send_byte(8'h7F);
        frame_end();
        read_chk("ctl_rd0", 0, 8'h20);
        read_chk("ctl_rd1", 1, 8'h20);

        // overflow with 65 bytes
        frame_start();
        for (int i = 0; i < 65; i++) send_byte(8'h21 + 8'(i));
        chk("ovf_set", bus.overflow, 1);
        frame_end();
        chk("ovf_frame_len", bus.frame_len, 64);
        read_chk("ovf_rd63", 63, m_read(63));
        chk("ovf_model_rd63", bus.rd_data, 8'h60);
        pulse_clear();
        chk("clr_overflow", bus.overflow, 0);
        chk("clr_frame_len", bus.frame_len, 0);
        read_chk("clr_rd0", 0, 8'h20);

        // wrapping TX message, tx_len = 3
        bus.tx_len = 7'd3;
        m_tx_len = 3;
        pulse_clear();
        chk("tx_first", bus.o_data, 8'h46);
        tx_exp = "ROFRO";
        for (int i = 0; i < 5; i++) begin
            tx_pulse();
            chk("tx_seq", bus.o_data, tx_exp[i]);
        end
        frame_start();
        frame_end();
        chk("tx_restart", bus.o_data, 8'h46);

        // byte and frame end in the same cycle
        frame_start();
        send_byte(8'h4A);
        send_byte(8'h4B);
        bus.i_data = 8'h41;
        bus.is_receiveing = 1'b1;
        cyc(2);
        bus.is_receiveing = 1'b0;
        bus.SS = 1'b1;
        cyc(5);
        m_rx(8'h41);
        m_end();
        chk("same_frame_len", bus.frame_len, 3);
        read_chk("same_rd2", 2, 8'h41);
        chk("same_done_cnt", done_cnt, exp_done);

        // empty frame: no swap, no pulse
        frame_start();
        frame_end();
        chk("empty_done_cnt", done_cnt, exp_done);
        chk("empty_frame_len", bus.frame_len, 3);
        read_chk("empty_rd0", 0, 8'h4A);

        // reset mid-frame
        frame_start();
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        btn_reset = 1'b0;
        #1;
        chk("midrst_frame_len", bus.frame_len, 0);
        chk("midrst_o_data", bus.o_data, 8'h00);
        bus.SS = 1'b1;
        cyc(2);
        btn_reset = 1'b1;
        m_power_on();
        cyc(1);
        chk("midrst_reload", bus.o_data, 8'h46);
        for (int i = 0; i < 3; i++) read_chk("midrst_rd", i, 8'h20);

        // randomized frames against the model
        for (int it = 0; it < 30; it++) begin
            int n;
            if ($urandom_range(0, 3) == 0) begin
                for (int w = 0; w < 3; w++) begin
                    int a;
                    logic [7:0] d;
                    a = $urandom_range(0, 15);
                    d = 8'($urandom);
                    bus.tx_wr_en = 1'b1;
                    bus.tx_wr_addr = ADDR_W'(a);
                    bus.tx_wr_data = d;
                    cyc(1);
                    bus.tx_wr_en = 1'b0;
                    m_mem[a] = d;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                m_tx_len = $urandom_range(0, 12);
                bus.tx_len = 7'(m_tx_len);
                frame_start();
                frame_end();
                chk("rnd_len_reload", bus.o_data, m_o);
            end
            if ($urandom_range(0, 7) == 0) begin
                pulse_clear();
                chk("rnd_clr_len", bus.frame_len, 0);
                chk("rnd_clr_o", bus.o_data, m_o);
            end
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 20);
            frame_start();
            for (int b = 0; b < n; b++) begin
                send_byte(8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    tx_pulse();
                    chk("rnd_tx", bus.o_data, m_o);
                end
            end
            frame_end();
            chk("rnd_frame_len", bus.frame_len, m_disp.size());
            chk("rnd_overflow", bus.overflow, m_ovf);
            chk("rnd_o_data", bus.o_data, m_o);
            chk("rnd_done_cnt", done_cnt, exp_done);
            for (int r = 0; r < 6; r++) begin
                int a;
                a = (r == 0) ? (m_disp.size() % DEPTH) : $urandom_range(0, DEPTH - 1);
                read_chk("rnd_rd", a, m_read(a));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s_msg_buffer.md
# s_msg_buffer

Parametrised SPI-slave message buffer that sits between `s_spi_control` and the display/font path in the slave top level. It collects received bytes into a double-buffered frame memory, with a frame delimited by `SS` deassertion. It serves a filtered, registered character read port to the screen logic and feeds a programmable, wrapping transmit message back to the SPI shifter. It adds several behaviours not present before: frame framing, bank swap, overflow detection, a programmable TX length and 2-flop synchronisation of the SPI-domain status lines.

## Interface
- `DATA_W`, 8, byte width
- `DEPTH`, 64, entries per RX bank and in TX memory (power of two)
- `ADDR_W`, 6, log2(DEPTH)
- `CHAR_MIN`, 32, lowest displayable code
- `CHAR_MAX`, 126, highest displayable code
- `FILL`, 32, code returned for empty/non-displayable positions

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `btn_reset`  in  1  asynchronous, active-low reset
- `soft_clear`  in  1  synchronous one-cycle clear (debounced button pulse)
- `is_receiveing`  in  1  SPI-domain level, high while a byte is shifting in
- `i_data`  in  DATA_W  last received byte; stable while `is_receiveing` low
- `is_transmitting`  in  1  SPI-domain level, high while a byte is shifting out
- `SS`  in  1  SPI slave select, active low
- `o_data`  out  DATA_W  next byte to transmit
- `tx_len`  in  ADDR_W+1  TX message length, 0..DEPTH
- `tx_wr_en`, `tx_wr_addr[ADDR_W]`, `tx_wr_data[DATA_W]`  in  TX memory write port
- `rd_addr`  in  ADDR_W  display read address
- `rd_data`  out  DATA_W  filtered character, 1-cycle latency
- `frame_len`  out  ADDR_W+1  length of the frame in the display bank
- `frame_done`  out  1  one-cycle pulse on bank swap
- `overflow`  out  1  sticky: a byte was dropped

## Operation
- Synchronisation: `is_receiveing`, `is_transmitting` and `SS` each pass through 2 flops, plus a third history flop. Events are detected on synchronised edges:
  - rx_evt: receive falling edge
  - tx_evt: transmit falling edge
  - end_evt: `SS` rising edge
- Banks: two RX banks of DEPTH×DATA_W. `bank_sel` picks the display bank; the other bank is the write bank.
- rx_evt:
  - If `wr_ptr` < DEPTH: write `i_data` to write bank[`wr_ptr`], then `wr_ptr`++ (width ADDR_W+1).
  - Else: drop the byte and set `overflow`.
- end_evt with `wr_ptr` > 0: toggle `bank_sel`, `frame_len` <= `wr_ptr`, pulse `frame_done`, `wr_ptr` <= 0.
- end_evt with `wr_ptr` = 0: no swap, no pulse.
- rx_evt and end_evt in the same cycle: the byte is included in the frame, so `frame_len` = `wr_ptr`+1 (capped at DEPTH, and `overflow` is set if the byte was dropped).
- Banks are never cleared. Positions with `rd_addr` >= `frame_len` read as FILL.
- Read port: `rd_data` <= FILL if `rd_addr` >= `frame_len` or display byte is outside [CHAR_MIN, CHAR_MAX]; otherwise it is the display bank byte.
- TX:
  - tx_evt: `tx_idx` <= (`tx_idx`+1 == `tx_len`) ? 0 : `tx_idx`+1, and `o_data` <= tx_mem[next idx]. The message wraps instead of running off the end.
  - end_evt: `tx_idx` <= 0 and `o_data` <= tx_mem[0]. Each frame restarts the message.
  - `tx_len` = 0: `o_data` is held at 0 and `tx_idx` stays 0.
- TX writes: `tx_wr_en` writes tx_mem immediately. `o_data` reflects the new contents only at the next tx_evt, end_evt or load.
- Initial tx_mem contents: "FROM SLAVE" in entries 0..9, 0 elsewhere.
- `soft_clear` clears:
  - `wr_ptr`, `frame_len`, `overflow`, `bank_sel`, `tx_idx` to 0
  - sets `tx_load`
  - memories are untouched
  - priority over all same-cycle events

## Timing
- Reset values: `o_data` = 0, `rd_data` = 0, `frame_len` = 0, `frame_done` = 0, `overflow` = 0. Internally `wr_ptr` = 0, `bank_sel` = 0, `tx_idx` = 0, `tx_load` = 1, and sync flops hold the idle state (`SS` = 1, busy = 0).
- First clock after reset release: `o_data` <= tx_mem[0] (when `tx_len` > 0) and `tx_load` <= 0.
- Event latency: an input edge is registered on the 3rd rising `clk` after it occurs, given setup. The write, swap or `o_data` update lands on that edge.
- `frame_done` is high for exactly one cycle, the same cycle `frame_len` and `bank_sel` change.
- `rd_data` updates one clock after `rd_addr`. A swap is visible on `rd_data` one clock after `frame_done`.
- Reset asserted mid-frame: all state is lost immediately and the partial frame is discarded.

## Test plan
- Reset, then send "HI" (0x48, 0x49) and raise `SS` → `frame_done` pulse, `frame_len` = 2. `rd_addr` 0/1/2 → 0x48 / 0x49 / 0x20.
- Send 65 bytes in one frame → first 64 stored, `overflow` = 1, `frame_len` = 64. `soft_clear` → `overflow` = 0, `frame_len` = 0.
- Send byte 0x07 then 0x7F → `rd_data` = 0x20 for both positions.
- `tx_len` = 3 with default memory, 5 transmit bytes → `o_data` sequence F, R, O, F, R, O. On `SS` rise → `o_data` = F.
- rx_evt and end_evt in the same cycle → `frame_len` includes the byte. A second frame with zero bytes → no `frame_done` and the display bank is unchanged.
- Assert `btn_reset` mid-frame after 3 bytes, then release → `frame_len` = 0, reads return 0x20, and `o_data` = F one clock after release.
